// File: rtl/cnn_image_feeder_if.sv
// rtl/cnn_image_feeder_if.sv - host load/start/result and CNN core signals of the image feeder
interface cnn_image_feeder_if #(parameter int DATA_W = 8);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              busy;
  logic              cnn_rst_n;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              cnn_finish;
  logic [3:0]        cnn_decision;
  logic [3:0]        result;
  logic              result_err;
  logic              result_valid;
  logic              result_ack;

  modport slave (
    input  load_valid, load_data, start, cnn_finish, cnn_decision, result_ack,
    output load_ready, busy, cnn_rst_n, pix_data, pix_valid, result, result_err, result_valid
  );

  modport master (
    output load_valid, load_data, start, cnn_finish, cnn_decision, result_ack,
    input  load_ready, busy, cnn_rst_n, pix_data, pix_valid, result, result_err, result_valid
  );
endinterface

// File: rtl/cnn_image_feeder.sv
// rtl/cnn_image_feeder.sv - buffers one image, resets the CNN core, streams pixels and latches its decision
module cnn_image_feeder #(
  parameter int PIXELS  = 784,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cnn_image_feeder_if.slave   io_bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FULL, S_CLR, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [PIXELS];
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_clr_cnt;
  logic              r_last;
  logic              r_load_ready;
  logic              r_busy;
  logic              r_cnn_rst_n;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic [3:0]        r_result;
  logic              r_result_err;
  logic              r_result_valid;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_rd_next;

  assign w_wr_en   = (r_state == S_IDLE) && r_load_ready && io_bus.load_valid;
  assign w_rd_next = (r_rd_ptr == LAST_ADDR) ? r_rd_ptr : r_rd_ptr + 1'b1;

  // Read runs every cycle; r_rd_ptr is the address whose data lands in r_rd_data next edge.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= io_bus.load_data;
    r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_clr_cnt      <= 1'b0;
      r_last         <= 1'b0;
      r_load_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_cnn_rst_n    <= 1'b0;
      r_pix_valid    <= 1'b0;
      r_pix_data     <= '0;
      r_result       <= 4'h0;
      r_result_err   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_load_ready <= 1'b1;
          r_cnn_rst_n  <= 1'b1;
          r_rd_ptr     <= '0;
          if (w_wr_en) begin
            if (r_wr_ptr == LAST_ADDR) begin
              r_wr_ptr     <= '0;
              r_load_ready <= 1'b0;
              r_state      <= S_FULL;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        S_FULL: begin
          r_load_ready <= 1'b0;
          if (io_bus.start) begin
            r_state     <= S_CLR;
            r_busy      <= 1'b1;
            r_cnn_rst_n <= 1'b0;
            r_clr_cnt   <= 1'b0;
            r_rd_ptr    <= '0;
          end
        end
        S_CLR: begin
          r_rd_ptr  <= w_rd_next;
          r_clr_cnt <= 1'b1;
          if (r_clr_cnt) begin
            r_state     <= S_STREAM;
            r_cnn_rst_n <= 1'b1;
            r_pix_valid <= 1'b1;
            r_pix_data  <= r_rd_data;
            r_last      <= 1'b0;
          end
        end
        S_STREAM: begin
          r_pix_valid <= 1'b1;
          r_pix_data  <= r_rd_data;
          r_rd_ptr    <= w_rd_next;
          // r_last marks that r_rd_data now holds the final pixel.
          if (r_last) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_last  <= 1'b0;
          end else begin
            r_last <= (r_rd_ptr == LAST_ADDR);
          end
        end
        S_WAIT: begin
          r_pix_valid <= 1'b0;
          r_pix_data  <= '0;
          r_rd_ptr    <= '0;
          if (io_bus.cnn_finish) begin
            r_result       <= io_bus.cnn_decision;
            r_result_err   <= 1'b0;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_DONE;
          end else if (r_cnt == CNT_MAX) begin
            r_result       <= 4'hF;
            r_result_err   <= 1'b1;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (io_bus.result_ack) begin
            r_result       <= 4'h0;
            r_result_err   <= 1'b0;
            r_result_valid <= 1'b0;
            r_load_ready   <= 1'b1;
            r_wr_ptr       <= '0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.load_ready   = r_load_ready;
  assign io_bus.busy         = r_busy;
  assign io_bus.cnn_rst_n    = r_cnn_rst_n;
  assign io_bus.pix_valid    = r_pix_valid;
  assign io_bus.pix_data     = r_pix_data;
  assign io_bus.result       = r_result;
  assign io_bus.result_err   = r_result_err;
  assign io_bus.result_valid = r_result_valid;
endmodule

// File: tb/tb_cnn_image_feeder.sv
// tb/tb_cnn_image_feeder.sv - directed-sequence bench with random images for cnn_image_feeder
module tb_cnn_image_feeder;
  localparam int PIX = 784;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] img [PIX];

  cnn_image_feeder_if #(.DATA_W(8)) io ();

  cnn_image_feeder #(.PIXELS(PIX), .DATA_W(8), .ADDR_W(10), .TIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({io.load_ready, io.busy, io.pix_valid, io.pix_data, io.cnn_rst_n,
                io.result, io.result_err, io.result_valid});
  endfunction

  task automatic load_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int w = 0;
      while (!io.load_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      io.load_valid = 1'b1;
      io.load_data  = img[i];
      @(negedge clk);
    end
    io.load_valid = 1'b0;
  endtask

  // mode 0: finish a few cycles into WAIT; 1: never finish; 2: finish on the timeout cycle
  task automatic run_job(input int mode, input logic [3:0] dec, input string tag);
    int e0, rstlow, first, last, rv, bad;
    logic [7:0] got [$];
    rstlow = 0; first = -1; last = -1; rv = -1; bad = 0;
    io.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    for (int k = 0; k < PIX + 200; k++) begin
      io.start      = 1'b0;
      io.cnn_finish = 1'b0;
      if (!io.cnn_rst_n) rstlow++;
      if (io.pix_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got.push_back(io.pix_data);
      end
      if (io.result_valid) begin
        rv = cyc;
        break;
      end
      if (mode == 0 && io.pix_valid && got.size() == 100) begin
        io.start = 1'b1;
        io.cnn_finish = 1'b1;
        io.cnn_decision = 4'd9;
      end
      if (mode == 0 && last >= 0 && !io.pix_valid && cyc == last + 5) begin
        io.cnn_finish = 1'b1;
        io.cnn_decision = dec;
      end
      if (mode == 2 && last >= 0 && cyc == last + TMO - 1) begin
        io.cnn_finish = 1'b1;
        io.cnn_decision = dec;
      end
      @(negedge clk);
    end
    io.start = 1'b0;
    io.cnn_finish = 1'b0;
    for (int i = 0; i < got.size() && i < PIX; i++)
      if (got[i] !== img[i]) bad++;
    chk({tag, ".rst_low_cycles"}, rstlow, 2);
    chk({tag, ".first_pix_cycle"}, first, e0 + 2);
    chk({tag, ".last_pix_cycle"}, last, e0 + PIX + 1);
    chk({tag, ".pix_count"}, got.size(), PIX);
    chk({tag, ".pix_data_errs"}, bad, 0);
    chk({tag, ".result_cycle"}, rv, (mode == 0) ? last + 6 : last + TMO);
    chk({tag, ".result"}, 32'(io.result), (mode == 1) ? 32'hF : 32'(dec));
    chk({tag, ".result_err"}, 32'(io.result_err), (mode == 1) ? 1 : 0);
    chk({tag, ".busy_done"}, 32'(io.busy), 0);
  endtask

  task automatic ack_job(input int hold, input string tag);
    logic [3:0] r0;
    logic err0;
    int chg;
    r0 = io.result; err0 = io.result_err; chg = 0;
    for (int k = 0; k < hold; k++) begin
      io.start = (k == 3);
      if (io.result !== r0 || io.result_err !== err0 || io.result_valid !== 1'b1 || io.busy !== 1'b0)
        chg++;
      @(negedge clk);
    end
    io.start = 1'b0;
    chk({tag, ".hold_changes"}, chg, 0);
    io.result_ack = 1'b1;
    @(negedge clk);
    io.result_ack = 1'b0;
    chk({tag, ".after_ack"}, out_vec(), 32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0}));
  endtask

  initial begin
    logic [3:0] dec;
    rst = 1'b1;
    io.load_valid = 1'b0; io.load_data = '0; io.start = 1'b0;
    io.cnn_finish = 1'b0; io.cnn_decision = '0; io.result_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_ready_rstn", 32'({io.load_ready, io.cnn_rst_n, io.busy}), 32'b110);

    for (int i = 0; i < PIX; i++) img[i] = 8'(i % 256);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    chk("start_in_idle", 32'({io.load_ready, io.busy}), 32'b10);

    load_range(0, 300);
    io.load_valid = 1'b1;
    #2 rst = 1'b1;
    #1 chk("async_reset_midload", out_vec(), 0);
    @(negedge clk);
    io.load_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    load_range(0, PIX - 1);
    chk("not_full_at_783", 32'(io.load_ready), 1);
    load_range(PIX - 1, PIX);
    chk("full_after_784", 32'({io.load_ready, io.busy}), 0);

    io.load_valid = 1'b1; io.load_data = 8'hA5; io.result_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_ignores_load_ack", 32'({io.load_ready, io.busy, io.result_valid}), 0);
    io.load_valid = 1'b0; io.result_ack = 1'b0;

    dec = 4'($urandom_range(0, 8));
    run_job(0, dec, "pattern");
    ack_job(50, "pattern");

    for (int i = 0; i < PIX; i++) img[i] = 8'($urandom);
    load_range(0, PIX);
    run_job(1, 4'd0, "timeout");
    ack_job(5, "timeout");

    for (int i = 0; i < PIX; i++) img[i] = 8'($urandom);
    load_range(0, PIX);
    dec = 4'($urandom_range(0, 9));
    run_job(2, dec, "finish_on_timeout");
    ack_job(5, "finish_on_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
